led_io_ctrl: RTL

Memory-mapped write front end for the seven-segment/LED display block. Decodes CPU I/O stores into three display channels, clamps values to what each channel can show, and queues them in a small FIFO. Drains the FIFO as paced one-cycle `ledwrite1`/`ledwrite2`/`ledwrite3` pulses with `ledwdata`. Provides shadow and status readback for CPU loads.

---
 rtl/led_io_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/led_io_ctrl.sv
// led_io_ctrl: decodes CPU I/O stores into three clamped display channels, queues them
// in a small FIFO and drains them as paced one-cycle ledwriteN pulses; shadow/status readback.
module led_io_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 2
) (
   input  logic        led_clk,
   input  logic        ledrst,
   input  logic        io_write,
   input  logic        io_read,
   input  logic [2:0]  io_addr,
   input  logic [31:0] io_wdata,
   output logic        io_ready,
   output logic [15:0] io_rdata,
   output logic        ledwrite1,
   output logic        ledwrite2,
   output logic        ledwrite3,
   output logic [15:0] ledwdata
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [3:0]    GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PULSE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [17:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_shadow_a;
   logic [15:0]   r_shadow_b;
   logic [15:0]   r_shadow_c;
   logic          r_sat;
   logic          r_drop;
   logic [1:0]    r_state;
   logic [3:0]    r_wait;
   logic          r_wr1;
   logic          r_wr2;
   logic          r_wr3;
   logic [15:0]   r_wdata;
   logic [15:0]   r_rdata;

   logic          w_addr_ok;
   logic          w_full;
   logic          w_push;
   logic          w_drop_ev;
   logic          w_clamped;
   logic          w_sat_ev;
   logic          w_status_rd;
   logic          w_slot;
   logic          w_pop;
   logic [15:0]   w_val;
   logic [17:0]   w_head;
   logic [15:0]   w_status;

   assign w_addr_ok   = (io_addr == 3'd0) || (io_addr == 3'd2) || (io_addr == 3'd4);
   assign w_full      = (r_count >= FULL_CNT);
   assign w_push      = io_write && w_addr_ok && !w_full;
   assign w_drop_ev   = io_write && w_addr_ok && w_full;
   assign w_sat_ev    = w_push && w_clamped;
   assign w_status_rd = io_read && (io_addr == 3'd6);
   assign w_head      = r_mem[r_rptr];
   assign w_status    = {9'b0, 5'(r_count), r_sat, r_drop};

   always_comb begin
      w_val     = 16'h0000;
      w_clamped = 1'b0;
      case (io_addr)
         3'd0: begin
            if ($signed(io_wdata) > 32'sd999) begin
               w_val     = 16'd999;
               w_clamped = 1'b1;
            end else if ($signed(io_wdata) < -32'sd999) begin
               w_val     = 16'hFC19;
               w_clamped = 1'b1;
            end else begin
               w_val = io_wdata[15:0];
            end
         end
         3'd2: begin
            if (io_wdata > 32'd9999) begin
               w_val     = 16'd9999;
               w_clamped = 1'b1;
            end else begin
               w_val = io_wdata[15:0];
            end
         end
         3'd4:    w_val = {8'h00, io_wdata[7:0]};
         default: w_val = 16'h0000;
      endcase
   end

   // A drain slot opens in IDLE and wherever the pacing would return to IDLE; launching
   // straight from there keeps the pulse period at GAP+1 with no extra IDLE cycle.
   assign w_slot = (r_state == S_IDLE)
                || ((r_state == S_PULSE) && (GAP == 0))
                || ((r_state == S_WAIT) && (r_wait == GAP_LAST));
   assign w_pop  = w_slot && (r_count != '0);

   assign io_ready  = !w_full;
   assign io_rdata  = r_rdata;
   assign ledwrite1 = r_wr1;
   assign ledwrite2 = r_wr2;
   assign ledwrite3 = r_wr3;
   assign ledwdata  = r_wdata;

   always_ff @(posedge led_clk) begin
      if (w_push) r_mem[r_wptr] <= {io_addr[2:1], w_val};
   end

   always_ff @(posedge led_clk) begin
      if (ledrst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge led_clk) begin
      if (ledrst) begin
         r_shadow_a <= '0;
         r_shadow_b <= '0;
         r_shadow_c <= '0;
         r_sat      <= 1'b0;
         r_drop     <= 1'b0;
         r_rdata    <= '0;
      end else begin
         if (w_push) begin
            case (io_addr)
               3'd0:    r_shadow_a <= w_val;
               3'd2:    r_shadow_b <= w_val;
               default: r_shadow_c <= w_val;
            endcase
         end
         // Status read clears the sticky flags, but a same-cycle event wins.
         r_sat  <= (r_sat  && !w_status_rd) || w_sat_ev;
         r_drop <= (r_drop && !w_status_rd) || w_drop_ev;
         if (io_read) begin
            case (io_addr)
               3'd0:    r_rdata <= r_shadow_a;
               3'd2:    r_rdata <= r_shadow_b;
               3'd4:    r_rdata <= r_shadow_c;
               3'd6:    r_rdata <= w_status;
               default: r_rdata <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge led_clk) begin
      if (ledrst) begin
         r_state <= S_IDLE;
         r_wait  <= '0;
         r_wr1   <= 1'b0;
         r_wr2   <= 1'b0;
         r_wr3   <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_wr1 <= w_pop && (w_head[17:16] == 2'd0);
         r_wr2 <= w_pop && (w_head[17:16] == 2'd1);
         r_wr3 <= w_pop && (w_head[17:16] == 2'd2);
         if (w_pop) begin
            r_wdata <= w_head[15:0];
            r_state <= S_PULSE;
         end else begin
            case (r_state)
               S_PULSE: begin
                  r_state <= (GAP == 0) ? S_IDLE : S_WAIT;
                  r_wait  <= '0;
               end
               S_WAIT: begin
                  if (r_wait == GAP_LAST) r_state <= S_IDLE;
                  else                    r_wait  <= r_wait + 4'd1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
